// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an optional iterative MUL/DIVU/REMU unit.
// Define EX_MULDIV_EN to build the 33-cycle multiply/divide FSM; otherwise ops 11-13 are illegal.
module ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        id_en,
   input  logic [31:0] id_pc,
   input  logic [3:0]  id_alu_op,
   input  logic [31:0] id_alu_in_0,
   input  logic [31:0] id_alu_in_1,
   input  logic [1:0]  id_mem_op,
   input  logic [31:0] id_mem_wr_data,
   input  logic [4:0]  id_rd_addr,
   input  logic        id_gpr_we_,
   input  logic [2:0]  id_exp_code,
   output logic [31:0] fwd_data,
   output logic        ex_busy,
   output logic        ex_en,
   output logic [31:0] ex_pc,
   output logic [1:0]  ex_mem_op,
   output logic [31:0] ex_mem_wr_data,
   output logic [4:0]  ex_rd_addr,
   output logic        ex_gpr_we_,
   output logic [2:0]  ex_exp_code,
   output logic [31:0] ex_out
);

   typedef enum logic [3:0] {
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
      OP_SLT, OP_SLTU, OP_MUL, OP_DIVU, OP_REMU
   } alu_op_e;

   typedef struct packed {
      logic        en;
      logic [31:0] pc;
      logic [1:0]  mem_op;
      logic [31:0] mem_wr_data;
      logic [4:0]  rd_addr;
      logic        gpr_we_;
      logic [2:0]  exp_code;
      logic [31:0] out;
   } ex_reg_t;

   localparam logic [2:0] EXP_ILLEGAL = 3'h2;
   localparam ex_reg_t EX_RESET = '{en: 1'b0, pc: '0, mem_op: '0, mem_wr_data: '0,
                                    rd_addr: '0, gpr_we_: 1'b1, exp_code: '0, out: '0};

   ex_reg_t     cur, nxt, from_id, bubble, multi_done;
   logic [31:0] alu_out;
   logic        op_multi, op_illegal, issue, in_busy, final_step;

`ifdef EX_MULDIV_EN
   assign op_multi   = id_alu_op inside {OP_MUL, OP_DIVU, OP_REMU};
   assign op_illegal = id_alu_op > OP_REMU;
`else
   assign op_multi   = 1'b0;
   assign op_illegal = id_alu_op > OP_SLTU;
`endif

   assign issue = !in_busy && id_en && op_multi;

   // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
   always_comb begin
      alu_out = '0;
      case (id_alu_op)
         OP_NOP:  alu_out = id_alu_in_1;
         OP_ADD:  alu_out = id_alu_in_0 + id_alu_in_1;
         OP_SUB:  alu_out = id_alu_in_0 - id_alu_in_1;
         OP_AND:  alu_out = id_alu_in_0 & id_alu_in_1;
         OP_OR:   alu_out = id_alu_in_0 | id_alu_in_1;
         OP_XOR:  alu_out = id_alu_in_0 ^ id_alu_in_1;
         OP_SLL:  alu_out = id_alu_in_0 << id_alu_in_1[4:0];
         OP_SRL:  alu_out = id_alu_in_0 >> id_alu_in_1[4:0];
         OP_SRA:  alu_out = $unsigned($signed(id_alu_in_0) >>> id_alu_in_1[4:0]);
         OP_SLT:  alu_out = {31'd0, $signed(id_alu_in_0) < $signed(id_alu_in_1)};
         OP_SLTU: alu_out = {31'd0, id_alu_in_0 < id_alu_in_1};
         default: alu_out = '0;
      endcase
   end

   always_comb begin
      from_id = '{en: 1'b1, pc: id_pc, mem_op: id_mem_op, mem_wr_data: id_mem_wr_data,
                  rd_addr: id_rd_addr, gpr_we_: id_gpr_we_, exp_code: id_exp_code, out: alu_out};
      if (op_illegal) begin
         from_id.gpr_we_ = 1'b1;
         from_id.out     = '0;
         // An upstream exception outranks the illegal-op code.
         if (id_exp_code == '0) from_id.exp_code = EXP_ILLEGAL;
      end

      bubble          = cur;
      bubble.en       = 1'b0;
      bubble.gpr_we_  = 1'b1;
      bubble.mem_op   = '0;
      bubble.exp_code = '0;
      bubble.out      = '0;

      nxt = cur;
      if (!stall) begin
         if (flush)               nxt = bubble;
         else if (in_busy)        nxt = final_step ? multi_done : bubble;
         else if (!id_en || issue) nxt = bubble;
         else                     nxt = from_id;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur <= EX_RESET;
      else       cur <= nxt;
   end

`ifdef EX_MULDIV_EN
   typedef enum logic {S_IDLE, S_BUSY} state_e;

   state_e      state;
   logic [4:0]  step;
   logic [3:0]  m_op;
   logic [31:0] m_a, m_b, m_acc, a_step, acc_step, m_pc, m_wr_data;
   logic [1:0]  m_mem_op;
   logic [4:0]  m_rd;
   logic        m_we_, rem_ge;
   logic [2:0]  m_exp;
   logic [32:0] rem_sh;

   assign in_busy    = (state == S_BUSY);
   assign final_step = (step == 5'd31);
   assign ex_busy    = !reset && (in_busy || issue);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         step  <= '0;
      end else if (!stall) begin
         if (flush) begin
            state <= S_IDLE;
            step  <= '0;
         end else if (in_busy) begin
            step <= step + 5'd1;
            if (final_step) state <= S_IDLE;
         end else if (issue) begin
            state <= S_BUSY;
            step  <= '0;
         end
      end
   end

   // NOTE: the operand/latch registers carry no reset; issue always loads them before BUSY reads them.
   always_ff @(posedge clk) begin
      if (!stall) begin
         if (issue) begin
            m_op      <= id_alu_op;
            m_a       <= id_alu_in_0;
            m_b       <= id_alu_in_1;
            m_acc     <= '0;
            m_pc      <= id_pc;
            m_mem_op  <= id_mem_op;
            m_wr_data <= id_mem_wr_data;
            m_rd      <= id_rd_addr;
            m_we_     <= id_gpr_we_;
            m_exp     <= id_exp_code;
         end else if (in_busy) begin
            m_a   <= a_step;
            m_acc <= acc_step;
         end
      end
   end

   // MUL adds the shifted multiplicand per set multiplier bit; DIVU/REMU shift the dividend
   // MSB-first into the remainder. A zero divisor naturally yields all-ones and the dividend.
   always_comb begin
      rem_sh   = {m_acc, m_a[31]};
      rem_ge   = rem_sh >= {1'b0, m_b};
      a_step   = m_a;
      acc_step = m_acc + (m_b[step] ? (m_a << step) : '0);
      if (m_op != OP_MUL) begin
         acc_step = rem_ge ? (rem_sh[31:0] - m_b) : rem_sh[31:0];
         a_step   = {m_a[30:0], rem_ge};
      end
      multi_done = '{en: 1'b1, pc: m_pc, mem_op: m_mem_op, mem_wr_data: m_wr_data,
                     rd_addr: m_rd, gpr_we_: m_we_, exp_code: m_exp, out: acc_step};
      if (m_op == OP_DIVU) multi_done.out = a_step;
   end
`else
   assign in_busy    = 1'b0;
   assign final_step = 1'b0;
   assign multi_done = EX_RESET;
   assign ex_busy    = 1'b0;
`endif

   assign fwd_data       = nxt.out;
   assign ex_en          = cur.en;
   assign ex_pc          = cur.pc;
   assign ex_mem_op      = cur.mem_op;
   assign ex_mem_wr_data = cur.mem_wr_data;
   assign ex_rd_addr     = cur.rd_addr;
   assign ex_gpr_we_     = cur.gpr_we_;
   assign ex_exp_code    = cur.exp_code;
   assign ex_out         = cur.out;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have these ports (clock and reset first):
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- stall  in  1  hold all pipeline registers and FSM
- flush  in  1  insert bubble / abort operation
- id_en  in  1  ID/EX data valid
- id_pc  in  `WORD_DATA_BUS (32)  instruction PC
- id_alu_op  in  4  ALU operation
- id_alu_in_0, id_alu_in_1  in  32 each  operands A, B
- id_mem_op  in  `MEM_OP_BUS (2)  passed through
- id_mem_wr_data  in  32  passed through
- id_rd_addr  in  `REG_ADDR_BUS (5)  passed through
- id_gpr_we_  in  1  GPR write enable, active-low
- id_exp_code  in  `EXP_CODE_BUS (3)  upstream exception
- fwd_data  out  32  combinational next-ex_out value, for forwarding
- ex_busy  out  1  multi-cycle op in progress; upstream must stall
- ex_en, ex_pc, ex_mem_op, ex_mem_wr_data, ex_rd_addr, ex_gpr_we_, ex_exp_code, ex_out  out  EX/MEM registers, widths as the matching id_* ports (ex_out 32); they feed the MEM stage.
REQ-002 SHALL use id_alu_op encoding: 0 NOP(out=B), 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 MUL (low 32 bits), 12 DIVU, 13 REMU; 14-15 illegal.

Function
REQ-003 SHALL compute ops 0-10 combinationally and register the result into ex_out at the next unstalled edge (1-cycle latency). Shifts use B[4:0]. Arithmetic wraps mod 2^32.
REQ-004 SHALL register all id_* pass-through fields into the matching ex_* registers at the same edge as ex_out.
REQ-005 SHALL implement the multi-cycle FSM IDLE->BUSY->IDLE with a 5-bit step counter for ops 11-13.
REQ-006 IDLE and id_en=1 with op 11-13: ex_busy SHALL be asserted combinationally that cycle. The edge SHALL latch operands and fields, clear the counter, move to BUSY, and load ex_en=0 as a bubble.
REQ-007 BUSY: ex_busy=1. SHALL perform one shift-add (MUL) or restoring-divide (DIVU/REMU) step per edge and increment the counter. Only the edge with counter==31 SHALL load the result and latched fields with ex_en=1 and return to IDLE. Total: 33 busy cycles; result visible after 33rd edge counting the accept edge.
REQ-008 SHALL ignore id_* inputs while BUSY.
REQ-009 Divisor 0: DIVU SHALL give 0xFFFFFFFF and REMU SHALL give the dividend; the op still takes the full 33 cycles.
REQ-010 fwd_data SHALL equal the value ex_out would load at the next edge; it SHALL be 0 during IDLE issue and non-final BUSY cycles.
REQ-011 Illegal op (14-15) with id_en=1: ex_exp_code SHALL be 3'h2 (illegal instruction), ex_gpr_we_=1, ex_out=0. A nonzero id_exp_code SHALL pass through unchanged and take precedence.
REQ-012 stall=1 SHALL hold every register, the FSM state and the counter. Stall SHALL take priority over flush.
REQ-013 flush=1 with stall=0 SHALL, at the edge: set ex_en=0, ex_gpr_we_=1, ex_mem_op=0, ex_exp_code=0, ex_out=0, and force FSM to IDLE (aborting any BUSY operation).
REQ-014 id_en=0 in IDLE SHALL load the bubble values of REQ-013.

Reset
REQ-015 reset=1 SHALL asynchronously force: FSM IDLE, counter 0, ex_en=0, ex_pc=0, ex_mem_op=0, ex_mem_wr_data=0, ex_rd_addr=0, ex_gpr_we_=1, ex_exp_code=0, ex_out=0; ex_busy=0 while reset is held.
REQ-016 Reset asserted mid-BUSY SHALL discard the operation; no result SHALL appear after release.

Configuration
REQ-017 Macro EX_MULDIV_EN:
- Defined: ops 11-13 behave per REQ-005..009.
- Undefined: no FSM or datapath is synthesized; ops 11-13 are treated as illegal per REQ-011; ex_busy is tied 0.

Verification
REQ-018 ADD A=0xFFFFFFFF, B=1, id_en=1 -> after 1 edge ex_out=0, ex_en=1, ex_busy=0.
REQ-019 MUL A=0x00010001, B=0x00010001 -> ex_busy high 33 cycles, then ex_out=0x00020001, ex_en=1 for one cycle.
REQ-020 DIVU A=100, B=0 -> ex_out=0xFFFFFFFF after 33 cycles; REMU A=100, B=7 -> ex_out=2.
REQ-021 DIVU issued, flush at 10th BUSY cycle -> IDLE next edge, ex_en=0, ex_busy=0, no result later.
REQ-022 MUL with stall=1 for 5 BUSY cycles -> result delayed exactly 5 cycles, value unchanged; stall+flush together -> registers hold.
REQ-023 op=14, id_en=1 -> ex_exp_code=2, ex_gpr_we_=1; with EX_MULDIV_EN undefined, op=11 -> same response, ex_busy=0.
